// File: rtl/mult_unit_if.sv
// mult_unit_if: start/operand request and busy/end/product response bundle for mult_unit
interface mult_unit_if #(
    parameter int WIDTH = 32
);
    logic                   mult_begin;
    logic                   mult_signed;
    logic [WIDTH-1:0]       mult_op1;
    logic [WIDTH-1:0]       mult_op2;
    logic                   busy;
    logic                   mult_end;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output mult_begin, mult_signed, mult_op1, mult_op2,
        input  busy, mult_end, product
    );

    modport slave (
        input  mult_begin, mult_signed, mult_op1, mult_op2,
        output busy, mult_end, product
    );
endinterface

// File: rtl/mult_unit.sv
// mult_unit: multi-cycle radix-2 shift-add multiplier, signed (MULT) and unsigned (MULTU)
module mult_unit #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    mult_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH);

    state_t               state, state_n;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic                 sign;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     mag1, mag2;

    assign mag1 = (bus.mult_signed && bus.mult_op1[WIDTH-1]) ? -bus.mult_op1 : bus.mult_op1;
    assign mag2 = (bus.mult_signed && bus.mult_op2[WIDTH-1]) ? -bus.mult_op2 : bus.mult_op2;

    assign bus.busy     = state != IDLE;
    assign bus.mult_end = state == DONE;
    assign bus.product  = product;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next state: RUN covers WIDTH add/shift steps plus one cycle that writes the signed product
    always_comb begin
        state_n = state == IDLE ? (bus.mult_begin ? RUN : IDLE) :
                  state == RUN  ? (cnt == LAST ? DONE : RUN)   : IDLE;
    end

    // datapath: latch magnitudes on start, shift-add while running, apply sign into product
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            sign    <= 1'b0;
            product <= '0;
        end else if (state == IDLE && bus.mult_begin) begin
            mcand  <= {{WIDTH{1'b0}}, mag1};
            mplier <= mag2;
            sign   <= bus.mult_signed & (bus.mult_op1[WIDTH-1] ^ bus.mult_op2[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            if (cnt == LAST) begin
                product <= sign ? -acc : acc;
            end else begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
        end
    end
endmodule
